// File: rtl/core_mem_responder_pkg.sv
// Shared core defines for the data-memory responder.
// Widths and LD/ST enable encodings match the core's enable_M coding.
package core_mem_responder_pkg;

    localparam int REG_SIZE     = 8;
    localparam int CORE_ID_SIZE = 4;
    localparam int ADDR_SIZE    = REG_SIZE + CORE_ID_SIZE;

    localparam logic [1:0] EN_LD  = 2'b01;
    localparam logic [1:0] EN_ST  = 2'b10;
    localparam logic [1:0] EN_ILL = 2'b11;

    function automatic logic is_req(input logic [1:0] en);
        return (en == EN_LD) || (en == EN_ST);
    endfunction

endpackage

// File: rtl/core_mem_responder_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr.
// Grant is one-hot plus its encoded index; the pointer lives in the parent.
module core_mem_responder_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    always_comb begin
        int j;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!gnt_valid && req[j]) begin
                gnt[j]    = 1'b1;
                gnt_idx   = IW'(j);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_mem_responder.sv
// Shared data-memory responder: one single-port array, one round-robin
// grant per cycle, registered ready pulse and load data.
module core_mem_responder
    import core_mem_responder_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int GW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2*NUM_CORES-1:0]         enable_M,
    input  logic [ADDR_SIZE*NUM_CORES-1:0] addr_M,
    input  logic [REG_SIZE*NUM_CORES-1:0]  wr_data_M,
    output logic [REG_SIZE-1:0]            rd_data_M,
    output logic [NUM_CORES-1:0]           ready_M,
    output logic                           err_illegal,
    output logic [GW-1:0]                  grant_id
);

    logic [NUM_CORES-1:0] req;
    logic [NUM_CORES-1:0] gnt;
    logic [NUM_CORES-1:0] ready_r;
    logic [GW-1:0]        ptr;
    logic [GW-1:0]        ptr_nxt;
    logic [GW-1:0]        gnt_idx;
    logic                 gnt_valid;
    logic                 any_ill;
    logic [1:0]           en_g;
    logic [ADDR_SIZE-1:0] addr_g;
    logic [REG_SIZE-1:0]  data_g;
    logic [REG_SIZE-1:0]  rd_data_r;
    logic [REG_SIZE-1:0]  mem [2**ADDR_SIZE];

    // A core showing ready is in its completion cycle with a stale request.
    always_comb begin
        req     = '0;
        any_ill = 1'b0;
        for (int c = 0; c < NUM_CORES; c++) begin
            req[c] = is_req(enable_M[2*c +: 2]) && !ready_r[c];
            if (enable_M[2*c +: 2] == EN_ILL) any_ill = 1'b1;
        end
    end

    core_mem_responder_rr_arbiter #(
        .N  (NUM_CORES),
        .IW (GW)
    ) u_arb (
        .req       (req),
        .ptr       (ptr),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign en_g    = enable_M[2*gnt_idx +: 2];
    assign addr_g  = addr_M[ADDR_SIZE*gnt_idx +: ADDR_SIZE];
    assign data_g  = wr_data_M[REG_SIZE*gnt_idx +: REG_SIZE];
    assign ptr_nxt = (gnt_idx == GW'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_r     <= '0;
            rd_data_r   <= '0;
            err_illegal <= 1'b0;
            grant_id    <= '0;
            ptr         <= '0;
        end else begin
            ready_r <= gnt;
            if (any_ill) err_illegal <= 1'b1;
            if (gnt_valid) begin
                ptr      <= ptr_nxt;
                grant_id <= gnt_idx;
                if (en_g == EN_LD) rd_data_r <= mem[addr_g];
            end
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (gnt_valid && en_g == EN_ST) mem[addr_g] <= data_g;
    end

    assign ready_M   = ready_r;
    assign rd_data_M = rd_data_r;

endmodule

// File: tb/tb_core_mem_responder.sv
// Bench for core_mem_responder: directed scenarios plus random traffic
// checked against a per-core request-queue model.
module tb_core_mem_responder;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [2*N-1:0]  enable_M = '0;
    logic [12*N-1:0] addr_M = '0;
    logic [8*N-1:0]  wr_data_M = '0;
    logic [7:0]      rd_data_M;
    logic [N-1:0]    ready_M;
    logic            err_illegal;
    logic [1:0]      grant_id;

    core_mem_responder #(.NUM_CORES(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_M    (enable_M),
        .addr_M      (addr_M),
        .wr_data_M   (wr_data_M),
        .rd_data_M   (rd_data_M),
        .ready_M     (ready_M),
        .err_illegal (err_illegal),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  en;
        logic [11:0] a;
        logic [7:0]  d;
    } op_t;

    op_t        q [N][$];
    logic [7:0] mmem [int];
    int         m_ptr;
    logic [N-1:0] m_ready;
    logic [7:0] m_rd;
    logic       m_err;
    int         m_gid;
    logic [N-1:0] prev_ready;
    int         log_g[$];
    logic [7:0] log_d[$];
    int         tests = 0;
    int         fails = 0;
    logic [11:0] pool [16];
    logic [N-1:0] seen_ready;

    function automatic op_t mk(input logic [1:0] en, input logic [11:0] a,
                               input logic [7:0] d);
        op_t o;
        o.en = en;
        o.a  = a;
        o.d  = d;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit busy();
        for (int c = 0; c < N; c++) if (q[c].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: cores react to ready, drive, model predicts, check.
    task automatic step();
        int g;
        for (int c = 0; c < N; c++)
            if (m_ready[c] && q[c].size() > 0) void'(q[c].pop_front());
        enable_M  = '0;
        addr_M    = '0;
        wr_data_M = '0;
        for (int c = 0; c < N; c++) begin
            if (q[c].size() > 0) begin
                enable_M[2*c +: 2]   = q[c][0].en;
                addr_M[12*c +: 12]   = q[c][0].a;
                wr_data_M[8*c +: 8]  = q[c][0].d;
                if (q[c][0].en == 2'b11) m_err = 1'b1;
            end
        end
        g = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (g < 0 && q[c].size() > 0 && !m_ready[c] &&
                (q[c][0].en == 2'b01 || q[c][0].en == 2'b10))
                g = c;
        end
        if (g >= 0) begin
            if (q[g][0].en == 2'b01) m_rd = mmem[int'(q[g][0].a)];
            else mmem[int'(q[g][0].a)] = q[g][0].d;
            m_ready    = '0;
            m_ready[g] = 1'b1;
            m_ptr      = (g + 1) % N;
            m_gid      = g;
        end else begin
            m_ready = '0;
        end
        @(posedge clk);
        #1;
        chk("ready_M", ready_M, m_ready);
        chk("rd_data_M", rd_data_M, m_rd);
        chk("err_illegal", err_illegal, m_err);
        chk("grant_id", grant_id, m_gid);
        chk("no_back_to_back", prev_ready & ready_M, 0);
        prev_ready = ready_M;
        seen_ready = seen_ready | ready_M;
        if (ready_M != '0) begin
            log_g.push_back(int'(grant_id));
            log_d.push_back(rd_data_M);
        end
    endtask

    task automatic run_idle();
        int n;
        n = 0;
        while ((busy() || m_ready != '0) && n < 100) begin
            step();
            n++;
        end
        chk("drain_timeout", n < 100, 1);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_async_ready", ready_M, 0);
        chk("rst_async_gid", grant_id, 0);
        chk("rst_async_err", err_illegal, 0);
        chk("rst_async_rd", rd_data_M, 0);
        for (int c = 0; c < N; c++) q[c].delete();
        enable_M   = '0;
        addr_M     = '0;
        wr_data_M  = '0;
        m_ready    = '0;
        m_ptr      = 0;
        m_rd       = '0;
        m_err      = 1'b0;
        m_gid      = 0;
        prev_ready = '0;
        @(posedge clk);
        #1;
        chk("rst_hold_ready", ready_M, 0);
        reset = 1'b0;
    endtask

    task automatic clear_log();
        log_g.delete();
        log_d.delete();
        seen_ready = '0;
    endtask

    initial begin
        m_ready    = '0;
        m_ptr      = 0;
        m_rd       = '0;
        m_err      = 1'b0;
        m_gid      = 0;
        prev_ready = '0;
        seen_ready = '0;
        do_reset();

        // 1: store then load by core 0
        clear_log();
        q[0].push_back(mk(2'b10, 12'h012, 8'hA5));
        q[0].push_back(mk(2'b01, 12'h012, 8'h00));
        run_idle();
        chk("t1_count", log_d.size(), 2);
        if (log_d.size() == 2) begin
            chk("t1_gid", log_g[1], 0);
            chk("t1_data", log_d[1], 8'hA5);
        end

        // 2: preload, reset, four simultaneous loads
        for (int i = 0; i < 4; i++)
            q[0].push_back(mk(2'b10, 12'h800 + 12'(i), 8'h10 + 8'(i)));
        run_idle();
        do_reset();
        clear_log();
        for (int c = 0; c < N; c++)
            q[c].push_back(mk(2'b01, 12'h800 + 12'(c), 8'h00));
        run_idle();
        chk("t2_count", log_g.size(), 4);
        if (log_g.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_order", log_g[i], i);
                chk("t2_data", log_d[i], 8'h10 + 8'(i));
            end
        end

        // 3: core 1 back-to-back, core 2 single
        clear_log();
        q[1].push_back(mk(2'b01, 12'h800, 8'h00));
        q[1].push_back(mk(2'b01, 12'h801, 8'h00));
        q[2].push_back(mk(2'b01, 12'h802, 8'h00));
        run_idle();
        chk("t3_count", log_g.size(), 3);
        if (log_g.size() == 3) begin
            chk("t3_g0", log_g[0], 1);
            chk("t3_g1", log_g[1], 2);
            chk("t3_g2", log_g[2], 1);
            chk("t3_d2", log_d[2], 8'h11);
        end

        // 4: store by core 3, load of same address by core 0 next cycle
        clear_log();
        q[3].push_back(mk(2'b10, 12'h0FF, 8'h7E));
        step();
        q[0].push_back(mk(2'b01, 12'h0FF, 8'h00));
        run_idle();
        chk("t4_count", log_g.size(), 2);
        if (log_g.size() == 2) begin
            chk("t4_gid", log_g[1], 0);
            chk("t4_data", log_d[1], 8'h7E);
        end

        // random traffic over a preloaded address pool
        for (int i = 0; i < 16; i++) begin
            pool[i] = 12'($urandom_range(0, 4095));
            q[1].push_back(mk(2'b10, pool[i], 8'($urandom)));
        end
        run_idle();
        for (int n = 0; n < 300; n++) begin
            for (int c = 0; c < N; c++) begin
                if (q[c].size() < 2 && $urandom_range(0, 2) == 0)
                    q[c].push_back(mk($urandom_range(0, 1) ? 2'b01 : 2'b10,
                                      pool[$urandom_range(0, 15)],
                                      8'($urandom)));
            end
            step();
        end
        run_idle();

        // 5: illegal enable on core 2
        clear_log();
        q[2].push_back(mk(2'b11, 12'h000, 8'h00));
        q[0].push_back(mk(2'b01, 12'h012, 8'h00));
        q[1].push_back(mk(2'b01, 12'h0FF, 8'h00));
        for (int i = 0; i < 6; i++) step();
        chk("t5_err", err_illegal, 1);
        chk("t5_served", log_g.size(), 2);
        chk("t5_no_ready2", seen_ready[2], 0);
        q[2].delete();
        for (int i = 0; i < 3; i++) step();
        chk("t5_err_sticky", err_illegal, 1);

        // 6: async reset while ready_M=0100, then core 0 wins
        q[2].push_back(mk(2'b01, 12'h012, 8'h00));
        step();
        chk("t6_pre_ready", ready_M, 4'b0100);
        do_reset();
        clear_log();
        q[0].push_back(mk(2'b01, 12'h012, 8'h00));
        q[3].push_back(mk(2'b01, 12'h012, 8'h00));
        run_idle();
        chk("t6_count", log_g.size(), 2);
        if (log_g.size() == 2) begin
            chk("t6_first_gid", log_g[0], 0);
            chk("t6_data", log_d[0], 8'hA5);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
